// File: rtl/dmem_arbiter_if.sv
// Bundle of core, debug and memory-side signals around the data-memory arbiter.
// The slave view belongs to the arbiter and the master view to its environment.
interface dmem_arbiter_if;
  logic        c_req;
  logic        c_we;
  logic [2:0]  c_funct3;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic        c_err;
  logic [31:0] c_rdata;
  logic        stall;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic        d_err;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_funct3, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_err, c_rdata, stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_err, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport master (
    output c_req, c_we, c_funct3, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_err, c_rdata, stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_err, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (core, debug) arbiter onto a single data-memory port with
// sub-word lane steering, alignment checking and an m_ack timeout.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic core_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] core_be(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (we) begin
      case (f3)
        3'b000:  be = 4'b0001 << off;
        3'b001:  be = 4'b0011 << off;
        default: be = 4'b1111;
      endcase
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  state_t           state_r;
  state_t           next_state_s;
  logic             last_dbg_r;
  logic             owner_dbg_r;
  logic             we_r;
  logic [1:0]       off_r;
  logic [3:0]       be_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [31:0]      rdata_r;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;

  logic        pick_dbg_s;
  logic        c_gnt_s;
  logic        d_gnt_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_legal_s;
  logic [3:0]  sel_be_s;
  logic        c_rvalid_s;
  logic        d_rvalid_s;

  // Arbitration, request selection and next-state decode
  always_comb begin
    next_state_s = state_r;
    c_gnt_s      = 1'b0;
    d_gnt_s      = 1'b0;
    pick_dbg_s   = bus.d_req & (~bus.c_req | ~last_dbg_r);
    sel_we_s     = bus.c_we;
    sel_addr_s   = bus.c_addr;
    sel_wdata_s  = bus.c_wdata;
    sel_legal_s  = 1'b0;
    sel_be_s     = 4'b1111;
    if (pick_dbg_s) begin
      sel_we_s    = bus.d_we;
      sel_addr_s  = bus.d_addr;
      sel_wdata_s = bus.d_wdata;
      sel_legal_s = (bus.d_addr[1:0] == 2'b00);
      sel_be_s    = 4'b1111;
    end else begin
      sel_legal_s = core_legal(bus.c_we, bus.c_funct3, bus.c_addr[1:0]);
      sel_be_s    = core_be(bus.c_we, bus.c_funct3, bus.c_addr[1:0]);
    end
    case (state_r)
      IDLE: begin
        // no grant while reset is held, since the capture would be discarded
        if ((bus.c_req | bus.d_req) & rst_n) begin
          c_gnt_s      = ~pick_dbg_s;
          d_gnt_s      = pick_dbg_s;
          next_state_s = sel_legal_s ? BUSY : RESP;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.m_ack) begin
          next_state_s = RESP;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = RESP;
        end else begin
          next_state_s = BUSY;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register plus request capture, response capture and timeout count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      last_dbg_r  <= 1'b1;
      owner_dbg_r <= 1'b0;
      we_r        <= 1'b0;
      off_r       <= 2'b00;
      be_r        <= 4'b0000;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      rdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
      cnt_r       <= '0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE: begin
          if (c_gnt_s | d_gnt_s) begin
            owner_dbg_r <= pick_dbg_s;
            last_dbg_r  <= pick_dbg_s;
            we_r        <= sel_we_s;
            off_r       <= sel_addr_s[1:0];
            be_r        <= sel_be_s;
            addr_r      <= {sel_addr_s[31:2], 2'b00};
            wdata_r     <= sel_wdata_s << {sel_addr_s[1:0], 3'b000};
            rdata_r     <= 32'h0000_0000;
            err_r       <= ~sel_legal_s;
            cnt_r       <= '0;
          end
        end
        BUSY: begin
          // an ack on the final allowed cycle still counts as success
          if (bus.m_ack) begin
            err_r   <= 1'b0;
            rdata_r <= we_r ? 32'h0000_0000 : (bus.m_rdata >> {off_r, 3'b000});
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              err_r <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign c_rvalid_s   = (state_r == RESP) & ~owner_dbg_r;
  assign d_rvalid_s   = (state_r == RESP) & owner_dbg_r;

  assign bus.c_gnt    = c_gnt_s;
  assign bus.d_gnt    = d_gnt_s;
  assign bus.c_rvalid = c_rvalid_s;
  assign bus.d_rvalid = d_rvalid_s;
  assign bus.c_err    = c_rvalid_s & err_r;
  assign bus.d_err    = d_rvalid_s & err_r;
  assign bus.c_rdata  = c_rvalid_s ? rdata_r : 32'h0000_0000;
  assign bus.d_rdata  = d_rvalid_s ? rdata_r : 32'h0000_0000;
  assign bus.stall    = bus.c_req & ~c_rvalid_s;

  assign bus.m_req    = (state_r == BUSY);
  assign bus.m_we     = (state_r == BUSY) & we_r;
  assign bus.m_be     = be_r;
  assign bus.m_addr   = addr_r;
  assign bus.m_wdata  = wdata_r;

endmodule
